// File: rtl/axi_node_pkg.sv
// rtl/axi_node_pkg.sv - shared constants, response encodings and rule-word packing helpers
package axi_node_pkg;

  localparam int unsigned ERR_CNT_W = 16;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  // Rule (r,m) lives at flat index r*n_master+m in every per-rule vector.
  function automatic int unsigned rule_bit(input int unsigned r, input int unsigned m,
                                           input int unsigned n_master);
    return r * n_master + m;
  endfunction

  function automatic int unsigned rule_lsb(input int unsigned r, input int unsigned m,
                                           input int unsigned n_master,
                                           input int unsigned addr_width);
    return (r * n_master + m) * addr_width;
  endfunction

endpackage

// File: rtl/axi_addr_decode_stage_if.sv
// rtl/axi_addr_decode_stage_if.sv - request/decision handshake bundle of the address decode stage
interface axi_addr_decode_stage_if #(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned N_MASTER_PORT = 16
);

  logic                     req_valid;
  logic                     req_ready;
  logic [ADDR_WIDTH-1:0]    req_addr;
  logic                     dec_valid;
  logic                     dec_ready;
  logic [ADDR_WIDTH-1:0]    dec_addr;
  logic [N_MASTER_PORT-1:0] dec_onehot;
  logic                     dec_error;

  modport master (
    output req_valid, req_addr, dec_ready,
    input  req_ready, dec_valid, dec_addr, dec_onehot, dec_error
  );

  modport slave (
    input  req_valid, req_addr, dec_ready,
    output req_ready, dec_valid, dec_addr, dec_onehot, dec_error
  );

endinterface

// File: rtl/axi_addr_rule_match.sv
// rtl/axi_addr_rule_match.sv - combinational region match for one decode target
module axi_addr_rule_match #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned N_REGION_MAX = 4
) (
  input  logic [ADDR_WIDTH-1:0]              addr_i,
  input  logic [N_REGION_MAX*ADDR_WIDTH-1:0] start_addr_i,
  input  logic [N_REGION_MAX*ADDR_WIDTH-1:0] end_addr_i,
  input  logic [N_REGION_MAX-1:0]            rule_en_i,
  output logic                               hit_o
);

  always_comb begin
    hit_o = 1'b0;
    for (int r = 0; r < int'(N_REGION_MAX); r++) begin
      if (rule_en_i[r] &&
          (addr_i >= start_addr_i[r*ADDR_WIDTH +: ADDR_WIDTH]) &&
          (addr_i <= end_addr_i[r*ADDR_WIDTH +: ADDR_WIDTH])) begin
        hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_addr_decode_stage.sv
// rtl/axi_addr_decode_stage.sv - two-stage elastic address decoder with error counter
// Define AXI_DEC_MULTIHIT_ERR_EN to flag more than one connected hit as a decode error.
module axi_addr_decode_stage
  import axi_node_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned N_REGION_MAX  = 4,
  parameter int unsigned N_MASTER_PORT = 16,
  parameter int unsigned N_SLAVE_PORT  = 16,
  parameter int unsigned SLAVE_IDX     = 0
) (
  input  logic                                        s_axi_aclk,
  input  logic                                        s_axi_areset,
  axi_addr_decode_stage_if.slave                      dec_if,
  input  logic [N_REGION_MAX*N_MASTER_PORT*ADDR_WIDTH-1:0] START_ADDR_i,
  input  logic [N_REGION_MAX*N_MASTER_PORT*ADDR_WIDTH-1:0] END_ADDR_i,
  input  logic [N_REGION_MAX*N_MASTER_PORT-1:0]       valid_rule_i,
  input  logic [N_SLAVE_PORT*N_MASTER_PORT-1:0]       connectivity_map_i,
  output logic [ERR_CNT_W-1:0]                        err_cnt_o
);

  localparam logic [N_MASTER_PORT-1:0] ONE_M = N_MASTER_PORT'(1);

  logic [N_MASTER_PORT-1:0] hit;
  logic [N_MASTER_PORT-1:0] conn_row;

  for (genvar m = 0; m < N_MASTER_PORT; m++) begin : g_target
    logic [N_REGION_MAX*ADDR_WIDTH-1:0] start_m;
    logic [N_REGION_MAX*ADDR_WIDTH-1:0] end_m;
    logic [N_REGION_MAX-1:0]            en_m;

    for (genvar r = 0; r < N_REGION_MAX; r++) begin : g_region
      assign start_m[r*ADDR_WIDTH +: ADDR_WIDTH] =
        START_ADDR_i[rule_lsb(r, m, N_MASTER_PORT, ADDR_WIDTH) +: ADDR_WIDTH];
      assign end_m[r*ADDR_WIDTH +: ADDR_WIDTH] =
        END_ADDR_i[rule_lsb(r, m, N_MASTER_PORT, ADDR_WIDTH) +: ADDR_WIDTH];
      assign en_m[r] = valid_rule_i[rule_bit(r, m, N_MASTER_PORT)];
    end

    axi_addr_rule_match #(
      .ADDR_WIDTH   (ADDR_WIDTH),
      .N_REGION_MAX (N_REGION_MAX)
    ) u_rule_match (
      .addr_i       (dec_if.req_addr),
      .start_addr_i (start_m),
      .end_addr_i   (end_m),
      .rule_en_i    (en_m),
      .hit_o        (hit[m])
    );
  end

  always_comb begin
    conn_row = '0;
    for (int s = 0; s < int'(N_SLAVE_PORT); s++) begin
      if (s == int'(SLAVE_IDX)) conn_row = connectivity_map_i[s*N_MASTER_PORT +: N_MASTER_PORT];
    end
  end

  logic                     s1_valid_q, s1_valid_d;
  logic [N_MASTER_PORT-1:0] s1_hit_q, s1_hit_d;
  logic [N_MASTER_PORT-1:0] s1_conn_q, s1_conn_d;
  logic [ADDR_WIDTH-1:0]    s1_addr_q, s1_addr_d;
  logic                     s2_valid_q, s2_valid_d;
  logic [N_MASTER_PORT-1:0] s2_onehot_q, s2_onehot_d;
  axi_resp_e                s2_resp_q, s2_resp_d;
  logic [ADDR_WIDTH-1:0]    s2_addr_q, s2_addr_d;
  logic [ERR_CNT_W-1:0]     err_cnt_q, err_cnt_d;

  logic                     s2_free;
  logic                     s1_adv;
  logic                     req_ready;
  logic                     accept;
  logic [N_MASTER_PORT-1:0] cand;
  logic [N_MASTER_PORT-1:0] onehot_c;

  // Lowest connected hit wins; the hit and connectivity row were captured at acceptance.
  always_comb begin
    cand     = s1_hit_q & s1_conn_q;
    onehot_c = cand & (~cand + ONE_M);
`ifdef AXI_DEC_MULTIHIT_ERR_EN
    if ((cand & (cand - ONE_M)) != '0) onehot_c = '0;
`endif
  end

  always_comb begin
    s2_free   = !s2_valid_q || dec_if.dec_ready;
    s1_adv    = s1_valid_q && s2_free;
    req_ready = !s_axi_areset && (!s1_valid_q || s2_free);
    accept    = dec_if.req_valid && req_ready;

    s1_valid_d  = s1_valid_q;
    s1_hit_d    = s1_hit_q;
    s1_conn_d   = s1_conn_q;
    s1_addr_d   = s1_addr_q;
    s2_valid_d  = s2_valid_q;
    s2_onehot_d = s2_onehot_q;
    s2_resp_d   = s2_resp_q;
    s2_addr_d   = s2_addr_q;
    err_cnt_d   = err_cnt_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_hit_d   = hit;
      s1_conn_d  = conn_row;
      s1_addr_d  = dec_if.req_addr;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s1_adv) begin
      s2_valid_d  = 1'b1;
      s2_onehot_d = onehot_c;
      s2_resp_d   = (onehot_c == '0) ? RESP_DECERR : RESP_OKAY;
      s2_addr_d   = s1_addr_q;
    end else if (s2_valid_q && dec_if.dec_ready) begin
      s2_valid_d = 1'b0;
    end

    if (s2_valid_q && dec_if.dec_ready && (s2_resp_q == RESP_DECERR) &&
        (err_cnt_q != ERR_CNT_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      s1_valid_q  <= 1'b0;
      s1_hit_q    <= '0;
      s1_conn_q   <= '0;
      s1_addr_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_onehot_q <= '0;
      s2_resp_q   <= RESP_OKAY;
      s2_addr_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_hit_q    <= s1_hit_d;
      s1_conn_q   <= s1_conn_d;
      s1_addr_q   <= s1_addr_d;
      s2_valid_q  <= s2_valid_d;
      s2_onehot_q <= s2_onehot_d;
      s2_resp_q   <= s2_resp_d;
      s2_addr_q   <= s2_addr_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign dec_if.req_ready  = req_ready;
  assign dec_if.dec_valid  = s2_valid_q;
  assign dec_if.dec_addr   = s2_addr_q;
  assign dec_if.dec_onehot = s2_onehot_q;
  assign dec_if.dec_error  = (s2_resp_q == RESP_DECERR);
  assign err_cnt_o         = err_cnt_q;

endmodule

// File: tb/tb_axi_addr_decode_stage.sv
// tb/tb_axi_addr_decode_stage.sv - randomized and directed bench for axi_addr_decode_stage
module tb_axi_addr_decode_stage;

  localparam int AW = 32;
  localparam int NR = 4;
  localparam int NM = 16;
  localparam int NS = 16;
  localparam int SIDX = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_addr_decode_stage_if #(.ADDR_WIDTH(AW), .N_MASTER_PORT(NM)) bus ();

  logic [AW-1:0] st [NR][NM];
  logic [AW-1:0] en [NR][NM];
  bit            vr [NR][NM];
  bit            cm [NS][NM];

  logic [NR*NM*AW-1:0] start_flat, end_flat;
  logic [NR*NM-1:0]    valid_flat;
  logic [NS*NM-1:0]    conn_flat;
  logic [15:0]         err_cnt;

  always_comb begin
    start_flat = '0;
    end_flat   = '0;
    valid_flat = '0;
    conn_flat  = '0;
    for (int r = 0; r < NR; r++)
      for (int m = 0; m < NM; m++) begin
        start_flat[(r*NM+m)*AW +: AW] = st[r][m];
        end_flat[(r*NM+m)*AW +: AW]   = en[r][m];
        valid_flat[r*NM+m]            = vr[r][m];
      end
    for (int s = 0; s < NS; s++)
      for (int m = 0; m < NM; m++) conn_flat[s*NM+m] = cm[s][m];
  end

  axi_addr_decode_stage #(
    .ADDR_WIDTH(AW), .N_REGION_MAX(NR), .N_MASTER_PORT(NM),
    .N_SLAVE_PORT(NS), .SLAVE_IDX(SIDX)
  ) dut (
    .s_axi_aclk         (clk),
    .s_axi_areset       (rst),
    .dec_if             (bus),
    .START_ADDR_i       (start_flat),
    .END_ADDR_i         (end_flat),
    .valid_rule_i       (valid_flat),
    .connectivity_map_i (conn_flat),
    .err_cnt_o          (err_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [15:0] oh;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] exp_cnt = 16'd0;

  function automatic exp_t predict(input logic [31:0] a);
    exp_t e;
    int   nhit;
    bit   h;
    nhit   = 0;
    e.addr = a;
    e.oh   = 16'h0;
    for (int m = 0; m < NM; m++) begin
      h = 1'b0;
      for (int r = 0; r < NR; r++)
        if (vr[r][m] && st[r][m] <= a && a <= en[r][m]) h = 1'b1;
      if (h && cm[SIDX][m]) begin
        nhit++;
        if (nhit == 1) e.oh = 16'(1) << m;
      end
    end
`ifdef AXI_DEC_MULTIHIT_ERR_EN
    if (nhit > 1) e.oh = 16'h0;
`endif
    e.err = (e.oh == 16'h0);
    return e;
  endfunction

  // Scoreboard: predictions are taken from the rules visible in the acceptance cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_cnt = 16'd0;
    end else begin
      if (bus.dec_valid) begin
        if (exp_q.size() == 0) chk("spurious_dec_valid", 1, 0);
        else begin
          chk("dec_addr", bus.dec_addr, exp_q[0].addr);
          chk("dec_onehot", bus.dec_onehot, exp_q[0].oh);
          chk("dec_error", bus.dec_error, exp_q[0].err);
          if (bus.dec_ready) begin
            chk("err_cnt", err_cnt, exp_cnt);
            if (exp_q[0].err && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            void'(exp_q.pop_front());
          end
        end
      end
      if (bus.req_valid && bus.req_ready) exp_q.push_back(predict(bus.req_addr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a);
    bit done;
    done = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = bus.req_ready;
      tick();
    end
    if (!done) chk("send_timeout", 0, 1);
    bus.req_valid = 1'b0;
  endtask

  task automatic await_out(output logic [15:0] oh, output logic er);
    bit seen;
    seen = 1'b0;
    oh   = 16'h0;
    er   = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.dec_valid) begin
        seen = 1'b1;
        oh   = bus.dec_onehot;
        er   = bus.dec_error;
      end
    end
    if (!seen) chk("await_timeout", 0, 1);
    tick();
  endtask

  task automatic drain();
    bus.req_valid = 1'b0;
    bus.dec_ready = 1'b1;
    for (int i = 0; i < 100 && (exp_q.size() != 0 || bus.dec_valid); i++) tick();
    chk("drain_empty", 64'(exp_q.size()), 0);
  endtask

  logic [15:0] oh;
  logic        er;
  logic [31:0] bp [4];
  int          accepted;
  bit          acc;
  int          rr, mm;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.dec_ready = 1'b1;
    for (int r = 0; r < NR; r++)
      for (int m = 0; m < NM; m++) begin
        st[r][m] = '0; en[r][m] = '0; vr[r][m] = 1'b0;
      end
    for (int s = 0; s < NS; s++)
      for (int m = 0; m < NM; m++) cm[s][m] = (s == SIDX);

    repeat (3) tick();
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_dec_valid", bus.dec_valid, 0);
    chk("rst_dec_onehot", bus.dec_onehot, 0);
    chk("rst_dec_error", bus.dec_error, 0);
    chk("rst_dec_addr", bus.dec_addr, 0);
    chk("rst_err_cnt", err_cnt, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", bus.req_ready, 1);
    tick();

    st[0][2] = 32'h1000; en[0][2] = 32'h1FFF; vr[0][2] = 1'b1;
    send(32'h1FFF);
    @(negedge clk);
    chk("lat_not_yet", bus.dec_valid, 0);
    tick();
    @(negedge clk);
    chk("lat_valid", bus.dec_valid, 1);
    chk("upper_bound_onehot", bus.dec_onehot, 16'h0004);
    chk("upper_bound_error", bus.dec_error, 0);
    tick();

    chk("errcnt_before", err_cnt, 0);
    send(32'h2000);
    await_out(oh, er);
    chk("nohit_onehot", oh, 0);
    chk("nohit_error", er, 1);
    @(negedge clk);
    chk("errcnt_after", err_cnt, 1);
    tick();

    st[1][3] = 32'h3000; en[1][3] = 32'h4FFF; vr[1][3] = 1'b1;
    st[2][5] = 32'h4000; en[2][5] = 32'h4000; vr[2][5] = 1'b1;
    send(32'h4000);
    await_out(oh, er);
`ifdef AXI_DEC_MULTIHIT_ERR_EN
    chk("multihit_onehot", oh, 16'h0000);
    chk("multihit_error", er, 1);
`else
    chk("multihit_onehot", oh, 16'h0008);
    chk("multihit_error", er, 0);
`endif

    cm[SIDX][2] = 1'b0;
    send(32'h1800);
    await_out(oh, er);
    chk("unconn_onehot", oh, 0);
    chk("unconn_error", er, 1);
    cm[SIDX][2] = 1'b1;
    send(32'h1800);
    vr[0][2] = 1'b0;
    await_out(oh, er);
    chk("late_rule_onehot", oh, 16'h0004);
    chk("late_rule_error", er, 0);
    vr[0][2] = 1'b1;
    drain();

    bp[0] = 32'h1000; bp[1] = 32'h2000; bp[2] = 32'h4000; bp[3] = 32'h1FFF;
    bus.dec_ready = 1'b0;
    accepted = 0;
    for (int c = 0; c < 5; c++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = bp[accepted];
      @(negedge clk);
      acc = bus.req_ready;
      tick();
      if (acc) accepted++;
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("bp_accepts", 64'(accepted), 2);
    chk("bp_req_ready", bus.req_ready, 0);
    chk("bp_held_addr", bus.dec_addr, 32'h1000);
    tick();
    bus.dec_ready = 1'b1;
    send(bp[2]);
    send(bp[3]);
    drain();

    bus.dec_ready = 1'b0;
    send(32'h1000);
    send(32'h2000);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_full", bus.dec_valid, 1);
    chk("midrst_ready", bus.req_ready, 0);
    tick();
    @(negedge clk);
    chk("midrst_dec_valid", bus.dec_valid, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_release_ready", bus.req_ready, 1);
    tick();

    for (int r = 0; r < NR; r++)
      for (int m = 0; m < NM; m++) begin
        st[r][m] = 32'($urandom_range(0, 1023));
        en[r][m] = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 1023))
                                               : st[r][m] + 32'($urandom_range(0, 96));
        vr[r][m] = ($urandom_range(0, 1) == 1);
      end
    for (int m = 0; m < NM; m++) cm[SIDX][m] = ($urandom_range(0, 3) != 0);

    for (int c = 0; c < 1500; c++) begin
      rr = $urandom_range(0, NR-1);
      mm = $urandom_range(0, NM-1);
      bus.req_valid = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0:       bus.req_addr = st[rr][mm];
        1:       bus.req_addr = en[rr][mm];
        default: bus.req_addr = 32'($urandom_range(0, 1023));
      endcase
      bus.dec_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) == 0) begin
        st[rr][mm] = 32'($urandom_range(0, 1023));
        en[rr][mm] = st[rr][mm] + 32'($urandom_range(0, 96));
        vr[rr][mm] = ~vr[rr][mm];
      end
      if ($urandom_range(0, 15) == 0) cm[SIDX][mm] = ~cm[SIDX][mm];
      tick();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
